ternary_memory: RTL and testbench

TERNARY_MEMORY -- requirements
Module: ternary_memory

---
 rtl/ternary_memory.sv | 122 ++++++++++++
 tb/tb_ternary_memory.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ternary_memory.sv
// Balanced-ternary word memory: 3^MEM_ADDR_SIZE words of WORD_SIZE trits.
// It has a CPU read/write port with 1-cycle registered reads and a host preload port.
module ternary_memory #(
    parameter int WORD_SIZE     = 9,
    parameter int MEM_ADDR_SIZE = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [2*MEM_ADDR_SIZE-1:0] mem_address,
    input  logic [2*WORD_SIZE-1:0]     mem_write_data,
    input  logic                       mem_read,
    input  logic                       mem_write,
    output logic [2*WORD_SIZE-1:0]     mem_read_data,
    output logic                       read_valid,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [2*MEM_ADDR_SIZE-1:0] load_address,
    input  logic [2*WORD_SIZE-1:0]     load_data,
    output logic                       error
);
    localparam int DEPTH = 3 ** MEM_ADDR_SIZE;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW    = 2 * MEM_ADDR_SIZE;
    localparam int DW    = 2 * WORD_SIZE;

    typedef enum logic {IDLE, RESP} state_t;

    function automatic logic addr_legal(input logic [AW-1:0] a);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MEM_ADDR_SIZE; i++)
            if (a[2*i +: 2] == 2'b11) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic data_legal(input logic [DW-1:0] d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < WORD_SIZE; i++)
            if (d[2*i +: 2] == 2'b11) ok = 1'b0;
        return ok;
    endfunction

    // Trit 0 is the least significant; offset by (DEPTH-1)/2 so all -1 lands on 0.
    function automatic logic [IDX_W-1:0] to_index(input logic [AW-1:0] a);
        int acc;
        acc = 0;
        for (int i = MEM_ADDR_SIZE - 1; i >= 0; i--) begin
            case (a[2*i +: 2])
                2'b01:   acc = acc * 3 + 1;
                2'b10:   acc = acc * 3 - 1;
                default: acc = acc * 3;
            endcase
        end
        return IDX_W'(acc + (DEPTH - 1) / 2);
    endfunction

    logic [DW-1:0]    mem [DEPTH];
    state_t           state;
    logic             run;
    logic             addr_ok, data_ok, ld_addr_ok, ld_data_ok;
    logic             rd_ok, wr_ok, ld_fire, ld_ok, fault;
    logic [IDX_W-1:0] cpu_idx, ld_idx;

    always_comb begin
        addr_ok    = addr_legal(mem_address);
        data_ok    = data_legal(mem_write_data);
        ld_addr_ok = addr_legal(load_address);
        ld_data_ok = data_legal(load_data);
        cpu_idx    = to_index(mem_address);
        ld_idx     = to_index(load_address);
        load_ready = run & ~mem_read & ~mem_write;
        rd_ok      = mem_read & ~mem_write & addr_ok;
        wr_ok      = mem_write & addr_ok & data_ok;
        ld_fire    = load_valid & load_ready;
        ld_ok      = ld_fire & ld_addr_ok & ld_data_ok;
        fault      = (mem_read & mem_write)
                   | ((mem_read | mem_write) & ~addr_ok)
                   | (mem_write & ~data_ok)
                   | (ld_fire & ~(ld_addr_ok & ld_data_ok));
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_ok)
            mem[cpu_idx] <= mem_write_data;
        else if (ld_ok)
            mem[ld_idx] <= load_data;
    end

    // run holds off the preload port until the first edge after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            run           <= 1'b0;
            read_valid    <= 1'b0;
            mem_read_data <= '0;
            error         <= 1'b0;
        end else begin
            run <= 1'b1;
            if (fault) error <= 1'b1;
            case (state)
                IDLE: begin
                    read_valid <= rd_ok;
                    if (rd_ok) begin
                        mem_read_data <= mem[cpu_idx];
                        state         <= RESP;
                    end
                end
                RESP: begin
                    read_valid <= rd_ok;
                    if (rd_ok) mem_read_data <= mem[cpu_idx];
                    else       state         <= IDLE;
                end
                default: begin
                    read_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ternary_memory.sv
// Directed bench for ternary_memory; expected read words are queued at issue
// and a negedge monitor pops them whenever read_valid is presented.
module tb_ternary_memory;
    localparam int WS = 9;
    localparam int AS = 4;

    localparam logic [2*AS-1:0] A_ZERO = 8'b00000000;  // index 40
    localparam logic [2*AS-1:0] A_NEG  = 8'b10101010;  // index 0
    localparam logic [2*AS-1:0] A_POS  = 8'b01010101;  // index 80
    localparam logic [2*AS-1:0] A_41   = 8'b00000001;
    localparam logic [2*AS-1:0] A_BAD  = 8'b00000011;

    localparam logic [2*WS-1:0] P1    = 18'h00001;
    localparam logic [2*WS-1:0] NEGW  = 18'h2AAAA;     // -9841
    localparam logic [2*WS-1:0] D_POS = 18'h00005;
    localparam logic [2*WS-1:0] D2    = 18'h00012;
    localparam logic [2*WS-1:0] D3    = 18'h00046;
    localparam logic [2*WS-1:0] D4    = 18'h11111;
    localparam logic [2*WS-1:0] BADD  = 18'h00003;

    logic            clock = 1'b0;
    logic            reset;
    logic [2*AS-1:0] mem_address, load_address;
    logic [2*WS-1:0] mem_write_data, load_data, mem_read_data;
    logic            mem_read, mem_write, read_valid, load_valid, load_ready, error;

    int checks = 0;
    int errors = 0;
    logic [2*WS-1:0] exp_q[$];

    ternary_memory #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS)) dut (
        .clock(clock), .reset(reset),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data), .read_valid(read_valid),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_address(load_address), .load_data(load_data),
        .error(error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [2*WS-1:0] act, input logic [2*WS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (read_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read_valid: got data %h expected no pulse", mem_read_data);
            end else begin
                chk("read_data", mem_read_data, exp_q.pop_front());
            end
        end
    end

    task automatic do_read(input logic [2*AS-1:0] a, input logic [2*WS-1:0] exp);
        mem_address = a;
        mem_read    = 1'b1;
        exp_q.push_back(exp);
        tick();
        mem_read = 1'b0;
    endtask

    task automatic do_write(input logic [2*AS-1:0] a, input logic [2*WS-1:0] d);
        mem_address    = a;
        mem_write_data = d;
        mem_write      = 1'b1;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic do_load(input logic [2*AS-1:0] a, input logic [2*WS-1:0] d);
        load_address = a;
        load_data    = d;
        load_valid   = 1'b1;
        #1 chk("load_ready_idle", 18'(load_ready), 18'd1);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mem_address = '0; load_address = '0;
        mem_write_data = '0; load_data = '0;
        mem_read = 1'b0; mem_write = 1'b0; load_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("reset_read_valid", 18'(read_valid), 18'd0);
        chk("reset_read_data", mem_read_data, 18'd0);
        chk("reset_error", 18'(error), 18'd0);
        chk("reset_load_ready", 18'(load_ready), 18'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Preload then CPU traffic, including back-to-back reads at both ends.
        do_load(A_ZERO, P1);
        do_read(A_ZERO, P1);
        tick();
        do_write(A_POS, D_POS);
        do_write(A_NEG, NEGW);
        do_read(A_NEG, NEGW);
        do_read(A_POS, D_POS);
        tick();

        // Read then write to the same word, then read-after-write.
        do_read(A_ZERO, P1);
        do_write(A_ZERO, D2);
        do_read(A_ZERO, D2);
        tick();
        chk("no_fault_error", 18'(error), 18'd0);

        // Illegal address trit.
        mem_address = A_BAD;
        mem_read    = 1'b1;
        tick();
        mem_read = 1'b0;
        chk("bad_addr_read_valid", 18'(read_valid), 18'd0);
        chk("bad_addr_data_held", mem_read_data, D2);
        chk("bad_addr_error", 18'(error), 18'd1);
        do_reset();
        chk("error_cleared", 18'(error), 18'd0);

        // Illegal data trit is not stored.
        do_write(A_POS, BADD);
        chk("bad_data_error", 18'(error), 18'd1);
        do_read(A_POS, D_POS);
        tick();

        // Reset while in RESP discards the read; array survives.
        mem_address = A_NEG;
        mem_read    = 1'b1;
        tick();
        mem_read = 1'b0;
        chk("resp_before_reset", 18'(read_valid), 18'd1);
        reset = 1'b0;
        #1;
        chk("midreset_read_valid", 18'(read_valid), 18'd0);
        chk("midreset_data", mem_read_data, 18'd0);
        chk("midreset_error", 18'(error), 18'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_reset_no_pulse", 18'(read_valid), 18'd0);
        do_read(A_ZERO, D2);
        do_read(A_NEG, NEGW);
        tick();

        // Simultaneous read and write: write wins, read dropped.
        mem_address    = A_41;
        mem_write_data = D3;
        mem_read       = 1'b1;
        mem_write      = 1'b1;
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
        chk("rw_read_valid", 18'(read_valid), 18'd0);
        chk("rw_data_held", mem_read_data, NEGW);
        chk("rw_error", 18'(error), 18'd1);
        tick();
        do_read(A_41, D3);
        tick();
        chk("error_sticky", 18'(error), 18'd1);

        // Preload stalls behind three CPU reads, then lands on the idle cycle.
        load_address = A_POS;
        load_data    = D4;
        load_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_address = (i == 0) ? A_ZERO : (i == 1) ? A_NEG : A_41;
            mem_read    = 1'b1;
            exp_q.push_back((i == 0) ? D2 : (i == 1) ? NEGW : D3);
            #1 chk("load_ready_busy", 18'(load_ready), 18'd0);
            @(posedge clock);
            #1;
        end
        mem_read = 1'b0;
        #1 chk("load_ready_free", 18'(load_ready), 18'd1);
        tick();
        load_valid = 1'b0;
        do_read(A_POS, D4);
        tick(); tick();

        chk("queue_drained", 18'(exp_q.size()), 18'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
